// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_tx_sched_pkg;

    typedef enum bit [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } sched_state;

    typedef enum bit {
        SRC_ALU = 1'b0,
        SRC_RF  = 1'b1
    } src_t;

    // Ceiling of the 4-bit retry counter.
    localparam int RETRY_MAX = 15;

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-requester round-robin arbiter. req[0] is the ALU, req[1] the RF.
// last_grant also serves as the "currently granted source" for the
// scheduler, because it is written on every grant and held until the next.
module rr_arb2
    import uart_tx_sched_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant,
    output logic       last_grant
);

    // One-hot grant; on a tie the source not served last wins.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == SRC_RF) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner; reset to RF so the ALU wins the first tie.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_grant <= SRC_RF;
        end else if (update && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: buffers one ALU word and one RF byte, picks
// between them round-robin and hands bytes to UART_TX with busy handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing granted; arbitrate pending sources, load byte 0
// SEND    | pulse tx_data_valid once tx_busy is low
// WAIT_HI | wait for tx_busy to rise; time out and re-send
// WAIT_LO | frame in flight; on busy fall go to next byte or finish
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int BUSY_WAIT_MAX = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    alu_valid,
    input  logic [2*DATA_WIDTH-1:0] alu_data,
    output logic                    alu_ready,
    input  logic                    rf_valid,
    input  logic [DATA_WIDTH-1:0]   rf_data,
    output logic                    rf_ready,
    input  logic                    tx_busy,
    output logic [DATA_WIDTH-1:0]   tx_p_data,
    output logic                    tx_data_valid,
    output logic                    sched_active,
    output logic [3:0]              retry_cnt
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_SEND    = SEND;
    localparam logic [1:0] S_WAIT_HI = WAIT_HI;
    localparam logic [1:0] S_WAIT_LO = WAIT_LO;

    logic [1:0]              state;
    logic                    alu_pend;
    logic                    rf_pend;
    logic [2*DATA_WIDTH-1:0] alu_hold;
    logic [DATA_WIDTH-1:0]   rf_hold;
    logic                    byte_idx;
    logic [3:0]              wait_cnt;
    logic [1:0]              grant;
    logic                    cur_src;
    logic                    byte_done;

    assign alu_ready     = !alu_pend;
    assign rf_ready      = !rf_pend;
    assign tx_data_valid = (state == S_SEND) && !tx_busy;
    assign sched_active  = (state != S_IDLE);
    assign byte_done     = (state == S_WAIT_LO) && !tx_busy;

    rr_arb2 u_arb (
        .CLK        (CLK),
        .RST        (RST),
        .req        ({rf_pend, alu_pend}),
        .update     (state == S_IDLE),
        .grant      (grant),
        .last_grant (cur_src)
    );

    // Holding registers: capture on valid && ready, release after last byte.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_pend <= 1'b0;
            rf_pend  <= 1'b0;
            alu_hold <= '0;
            rf_hold  <= '0;
        end else begin
            if (alu_valid && !alu_pend) begin
                alu_pend <= 1'b1;
                alu_hold <= alu_data;
            end else if (byte_done && (cur_src == SRC_ALU) && byte_idx) begin
                alu_pend <= 1'b0;
            end
            if (rf_valid && !rf_pend) begin
                rf_pend <= 1'b1;
                rf_hold <= rf_data;
            end else if (byte_done && (cur_src == SRC_RF)) begin
                rf_pend <= 1'b0;
            end
        end
    end

    // Send sequencer, byte register, busy-timeout and retry counters.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            byte_idx  <= 1'b0;
            wait_cnt  <= '0;
            retry_cnt <= '0;
            tx_p_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant != 2'b00) begin
                        state     <= S_SEND;
                        byte_idx  <= 1'b0;
                        tx_p_data <= grant[0] ? alu_hold[DATA_WIDTH-1:0] : rf_hold;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        state    <= S_WAIT_HI;
                        wait_cnt <= '0;
                    end
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        state <= S_WAIT_LO;
                    end else if (wait_cnt == 4'(BUSY_WAIT_MAX - 1)) begin
                        // UART_TX never acknowledged: re-send the same byte.
                        state <= S_SEND;
                        if (retry_cnt != 4'(RETRY_MAX)) begin
                            retry_cnt <= retry_cnt + 4'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if ((cur_src == SRC_ALU) && !byte_idx) begin
                            byte_idx  <= 1'b1;
                            tx_p_data <= alu_hold[2*DATA_WIDTH-1:DATA_WIDTH];
                            state     <= S_SEND;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
